// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer: prescaler, auto-reload counter, sticky overflow flag
// and level interrupt on the core data bus.
module mmio_timer #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wData,
  output logic [31:0]       rData,
  output logic              irq
);

  logic        en_r;
  logic        arl_r;
  logic        ien_r;
  logic [31:0] psc_r;
  logic [31:0] arr_r;
  logic [31:0] cnt_r;
  logic        ovf_r;
  logic [31:0] pcnt_r;

  logic [2:0]  wordOff_s;
  logic        wrCtrl_s;
  logic        wrPsc_s;
  logic        wrArr_s;
  logic        wrCnt_s;
  logic        wrStatus_s;
  logic        tick_s;
  logic        atTop_s;
  logic        ovfSet_s;

  assign wordOff_s  = addr[4:2];
  assign wrCtrl_s   = sel & we & (wordOff_s == 3'd0);
  assign wrPsc_s    = sel & we & (wordOff_s == 3'd1);
  assign wrArr_s    = sel & we & (wordOff_s == 3'd2);
  assign wrCnt_s    = sel & we & (wordOff_s == 3'd3);
  assign wrStatus_s = sel & we & (wordOff_s == 3'd4);

  // A PSC write restarts the prescaler and suppresses any tick on that edge.
  assign tick_s   = en_r & (pcnt_r == psc_r) & ~wrPsc_s;
  assign atTop_s  = (cnt_r == arr_r);
  assign ovfSet_s = tick_s & atTop_s;

  // Prescaler counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_r <= 32'd0;
    end else if (wrPsc_s) begin
      pcnt_r <= 32'd0;
    end else if (en_r) begin
      if (pcnt_r == psc_r) begin
        pcnt_r <= 32'd0;
      end else begin
        pcnt_r <= pcnt_r + 32'd1;
      end
    end else begin
      pcnt_r <= pcnt_r;
    end
  end

  // Control, prescale and reload registers; software writes beat the one-shot stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_r  <= 1'b0;
      arl_r <= 1'b0;
      ien_r <= 1'b0;
      psc_r <= 32'd0;
      arr_r <= 32'd0;
    end else begin
      if (wrCtrl_s) begin
        en_r  <= wData[0];
        arl_r <= wData[1];
        ien_r <= wData[2];
      end else if (ovfSet_s && !arl_r) begin
        en_r  <= 1'b0;
      end
      if (wrPsc_s) begin
        psc_r <= wData;
      end
      if (wrArr_s) begin
        arr_r <= wData;
      end
    end
  end

  // Main counter; above ARR it wraps at 2^32 without flagging overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 32'd0;
    end else if (wrCnt_s) begin
      cnt_r <= wData;
    end else if (tick_s) begin
      if (atTop_s) begin
        cnt_r <= 32'd0;
      end else begin
        cnt_r <= cnt_r + 32'd1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sticky overflow flag; a hardware set outranks a same-edge W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovfSet_s | (ovf_r & ~(wrStatus_s & wData[0]));
    end
  end

  // Read mux.
  always_comb begin
    rData = 32'd0;
    if (sel) begin
      case (wordOff_s)
        3'd0:    rData = {29'd0, ien_r, arl_r, en_r};
        3'd1:    rData = psc_r;
        3'd2:    rData = arr_r;
        3'd3:    rData = cnt_r;
        3'd4:    rData = {31'd0, ovf_r};
        default: rData = 32'd0;
      endcase
    end else begin
      rData = 32'd0;
    end
  end

  assign irq = ovf_r & ien_r;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer; expected values are hand-derived
// from the register map and tick timing.
module tb_mmio_timer;

  localparam logic [4:0] A_CTRL = 5'h00;
  localparam logic [4:0] A_PSC  = 5'h04;
  localparam logic [4:0] A_ARR  = 5'h08;
  localparam logic [4:0] A_CNT  = 5'h0C;
  localparam logic [4:0] A_STAT = 5'h10;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wData;
  logic [31:0] rData;
  logic        irq;

  int nChecks;
  int nFails;
  logic [31:0] rd;

  mmio_timer #(.ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wData (wData),
    .rData (rData),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus write; the posedge inside is the write edge.
  task automatic wrReg(input logic [4:0] a, input logic [31:0] d, input logic s = 1'b1);
    @(negedge clk);
    sel = s; we = 1'b1; addr = a; wData = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0; wData = 32'd0;
  endtask

  task automatic rdReg(input logic [4:0] a, output logic [31:0] d, input logic s = 1'b1);
    sel = s; we = 1'b0; addr = a;
    #1;
    d = rData;
    sel = 1'b0;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < 8; i++) begin
      rdReg(5'(i * 4), rd);
      checkEq(tag, rd, 32'd0);
    end
    checkEq({tag, "_irq"}, {31'd0, irq}, 32'd0);
  endtask

  logic [31:0] perExp [8];
  logic [31:0] osExp  [6];
  logic [31:0] wrapExp[5];

  initial begin
    nChecks = 0; nFails = 0;
    reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 5'd0; wData = 32'd0;
    perExp  = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    osExp   = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd0};
    wrapExp = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkAllZero("por");

    // Reset with all registers non-zero and ovf/irq active.
    wrReg(A_ARR, 32'd0);
    wrReg(A_CTRL, 32'd7);
    nextEdge();
    checkEq("pre_rst_irq", {31'd0, irq}, 32'd1);
    wrReg(A_PSC, 32'd5);
    wrReg(A_ARR, 32'd9);
    wrReg(A_CNT, 32'd3);
    pulseReset();
    checkAllZero("rst");

    // Periodic: PSC=0, ARR=3, CTRL=0b111 at E0.
    wrReg(A_ARR, 32'd3);
    wrReg(A_CTRL, 32'd7);
    for (int k = 0; k < 4; k++) begin
      nextEdge();
      rdReg(A_CNT, rd);
      checkEq("per_cnt", rd, perExp[k]);
      if (k == 2) checkEq("per_irq_lo", {31'd0, irq}, 32'd0);
    end
    rdReg(A_STAT, rd);
    checkEq("per_ovf_e4", rd, 32'd1);
    checkEq("per_irq_e4", {31'd0, irq}, 32'd1);
    wrReg(A_STAT, 32'd1);                       // E5: clear
    rdReg(A_CNT, rd);
    checkEq("per_cnt_e5", rd, 32'd1);
    rdReg(A_STAT, rd);
    checkEq("per_w1c", rd, 32'd0);
    checkEq("per_irq_clr", {31'd0, irq}, 32'd0);
    for (int k = 5; k < 8; k++) begin
      nextEdge();
      rdReg(A_CNT, rd);
      checkEq("per_cnt2", rd, perExp[k]);
    end
    rdReg(A_STAT, rd);
    checkEq("per_ovf_e8", rd, 32'd1);

    // W1C colliding with overflow at E12: set wins.
    wrReg(A_STAT, 32'd1);                       // E9
    rdReg(A_STAT, rd);
    checkEq("col_pre", rd, 32'd0);
    nextEdge();                                 // E10
    nextEdge();                                 // E11
    wrReg(A_STAT, 32'd1);                       // E12 overflow
    rdReg(A_STAT, rd);
    checkEq("col_w1c_ovf", rd, 32'd1);
    rdReg(A_CNT, rd);
    checkEq("col_cnt_e12", rd, 32'd0);
    wrReg(A_CNT, 32'h10);                       // E13 tick edge
    rdReg(A_CNT, rd);
    checkEq("col_cnt_wr", rd, 32'h10);
    nextEdge();
    rdReg(A_CNT, rd);
    checkEq("col_cnt_above", rd, 32'h11);

    // One-shot: PSC=2, ARR=1, CTRL=0b001 at E0.
    wrReg(A_CTRL, 32'd0);
    wrReg(A_STAT, 32'd1);
    wrReg(A_PSC, 32'd2);
    wrReg(A_ARR, 32'd1);
    wrReg(A_CNT, 32'd0);
    wrReg(A_CTRL, 32'd1);
    for (int k = 0; k < 6; k++) begin
      nextEdge();
      rdReg(A_CNT, rd);
      checkEq("os_cnt", rd, osExp[k]);
    end
    rdReg(A_STAT, rd);
    checkEq("os_ovf", rd, 32'd1);
    rdReg(A_CTRL, rd);
    checkEq("os_en_clr", rd, 32'd0);
    checkEq("os_irq_masked", {31'd0, irq}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    rdReg(A_CNT, rd);
    checkEq("os_hold", rd, 32'd0);

    // CNT above ARR wraps through 2^32 without ovf.
    wrReg(A_STAT, 32'd1);
    wrReg(A_PSC, 32'd0);
    wrReg(A_ARR, 32'd2);
    wrReg(A_CNT, 32'hFFFF_FFFE);
    wrReg(A_CTRL, 32'd3);
    for (int k = 0; k < 5; k++) begin
      nextEdge();
      rdReg(A_CNT, rd);
      checkEq("wrap_cnt", rd, wrapExp[k]);
      rdReg(A_STAT, rd);
      checkEq("wrap_ovf", rd, (k == 4) ? 32'd1 : 32'd0);
    end

    // Decode.
    rdReg(5'h14, rd);
    checkEq("dec_0x14", rd, 32'd0);
    rdReg(5'h1C, rd);
    checkEq("dec_0x1c", rd, 32'd0);
    rdReg(A_ARR, rd, 1'b0);
    checkEq("dec_nosel_rd", rd, 32'd0);
    wrReg(A_ARR, 32'h55, 1'b0);
    rdReg(A_ARR, rd);
    checkEq("dec_nosel_wr", rd, 32'd2);

    // Reset mid-count with PSC=5.
    wrReg(A_CTRL, 32'd0);
    wrReg(A_CNT, 32'd0);
    wrReg(A_ARR, 32'd100);
    wrReg(A_PSC, 32'd5);
    wrReg(A_CTRL, 32'd1);
    repeat (3) nextEdge();
    pulseReset();
    rdReg(A_CNT, rd);
    checkEq("mid_rst_cnt", rd, 32'd0);
    rdReg(A_PSC, rd);
    checkEq("mid_rst_psc", rd, 32'd0);
    repeat (5) nextEdge();
    rdReg(A_CNT, rd);
    checkEq("mid_rst_notick", rd, 32'd0);
    // Prescaler must restart from zero: PSC=0 ticks on the first edge.
    wrReg(A_ARR, 32'd9);
    wrReg(A_CTRL, 32'd1);
    nextEdge();
    rdReg(A_CNT, rd);
    checkEq("mid_rst_restart", rd, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
